// File: rtl/grant_dispatch_pkg.sv
// grant_dispatch_pkg: shared types and constants for the grant dispatcher.
//   state_t      : session FSM states
//   uid_t        : encoded user id (0=U1 .. 3=U4)
//   U1_G..U4_G   : one-hot grant words, U1 in the MSB
//   onehot_to_id : one-hot grant word -> uid_t (0 for non-one-hot input)
package grant_dispatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   typedef logic [1:0] uid_t;

   localparam int         NUM_USERS = 4;
   localparam logic [3:0] U1_G      = 4'b1000;
   localparam logic [3:0] U2_G      = 4'b0100;
   localparam logic [3:0] U3_G      = 4'b0010;
   localparam logic [3:0] U4_G      = 4'b0001;

   function automatic uid_t onehot_to_id(input logic [3:0] g);
      uid_t id;
      id = 2'd0;
      case (g)
         U1_G:    id = 2'd0;
         U2_G:    id = 2'd1;
         U3_G:    id = 2'd2;
         U4_G:    id = 2'd3;
         default: id = 2'd0;
      endcase
      return id;
   endfunction

endpackage

// File: rtl/grant_onehot_chk.sv
// grant_onehot_chk: combinational classifier for a 4-bit grant word.
//   grant     in  4  grant word, bit3=U1 .. bit0=U4
//   is_onehot out 1  exactly one bit set
//   is_zero   out 1  no bit set
//   id        out 2  encoded user when one-hot, 0 otherwise
module grant_onehot_chk
   import grant_dispatch_pkg::*;
(
   input  logic [3:0] grant,
   output logic       is_onehot,
   output logic       is_zero,
   output uid_t       id
);

   assign is_zero   = (grant == 4'b0000);
   // clearing the lowest set bit leaves zero only for a single-bit word
   assign is_onehot = !is_zero && ((grant & (grant - 4'd1)) == 4'b0000);
   assign id        = onehot_to_id(grant);

endmodule

// File: rtl/grant_dispatch.sv
// grant_dispatch: turns new one-hot arbiter grants into start/select sessions,
// waits for the granted user's done or a timeout, buffers one grant arriving
// mid-session and flags malformed grant words.
//   clock, rst_n   clock / async active-low reset
//   grant_i[3:0]   arbiter grant word (bit3=U1 .. bit0=U4)
//   done_i[3:0]    per-user session complete, same order
//   err_clr_i      clears err_o / ovr_o
//   sel_o[3:0]     one-hot select of the user in session
//   start_o        first cycle of a session
//   active_id_o    encoded user of the current session
//   busy_o         session in progress (ISSUE or HOLD)
//   timeout_o      session ended by timeout
//   err_o, ovr_o   sticky: bad grant word / pending slot overwritten
//   grant_cnt_o    per-user saturating session counters, U1 in MSBs
// Option macro GRANT_DISPATCH_STATS_EN builds the counters; without it
// grant_cnt_o is tied to zero.
module grant_dispatch
   import grant_dispatch_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic [3:0]         grant_i,
   input  logic [3:0]         done_i,
   input  logic               err_clr_i,
   output logic [3:0]         sel_o,
   output logic               start_o,
   output logic [1:0]         active_id_o,
   output logic               busy_o,
   output logic               timeout_o,
   output logic               err_o,
   output logic               ovr_o,
   output logic [4*CNT_W-1:0] grant_cnt_o
);

   localparam int               TMR_W    = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   logic [3:0]       g_q;
   logic             g_onehot, g_zero;
   uid_t             g_id;
   logic             ev, ev_ok, ev_bad;
   state_t           state_q, state_d;
   uid_t             id_q;
   logic             pend_v_q;
   uid_t             pend_id_q;
   logic [TMR_W-1:0] timer_q;
   logic [3:0]       id_sel;
   logic             done_hit, tmo_hit, ovr_set;

   grant_onehot_chk u_chk (
      .grant     (grant_i),
      .is_onehot (g_onehot),
      .is_zero   (g_zero),
      .id        (g_id)
   );

   // a held grant level is not a new request; only a change to nonzero is
   assign ev       = (grant_i != g_q) && !g_zero;
   assign ev_ok    = ev && g_onehot;
   assign ev_bad   = ev && !g_onehot;
   assign id_sel   = U1_G >> id_q;
   assign done_hit = (state_q == HOLD) && |(done_i & id_sel);
   assign tmo_hit  = (state_q == HOLD) && !done_hit && (timer_q == TMR_LAST);
   assign ovr_set  = (state_q != IDLE) && ev_ok && pend_v_q;

   // state register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pend_v_q || ev_ok) state_d = ISSUE;
         ISSUE:   state_d = HOLD;
         HOLD:    if (done_hit || tmo_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      start_o     = 1'b0;
      busy_o      = 1'b0;
      sel_o       = 4'b0000;
      active_id_o = 2'd0;
      timeout_o   = 1'b0;
      case (state_q)
         ISSUE: begin
            start_o     = 1'b1;
            busy_o      = 1'b1;
            sel_o       = id_sel;
            active_id_o = id_q;
         end
         HOLD: begin
            busy_o      = 1'b1;
            sel_o       = id_sel;
            active_id_o = id_q;
            timeout_o   = tmo_hit;
         end
         default: ;
      endcase
   end

   // grant history, session id, pending slot, timer, sticky flags
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         g_q       <= 4'b0000;
         id_q      <= 2'd0;
         pend_v_q  <= 1'b0;
         pend_id_q <= 2'd0;
         timer_q   <= '0;
         err_o     <= 1'b0;
         ovr_o     <= 1'b0;
      end else begin
         g_q     <= grant_i;
         timer_q <= (state_q == HOLD) ? timer_q + 1'b1 : '0;
         if (state_q == IDLE) begin
            if (pend_v_q) begin
               // pending wins; a same-cycle event takes the freed slot
               id_q      <= pend_id_q;
               pend_v_q  <= ev_ok;
               pend_id_q <= g_id;
            end else if (ev_ok) begin
               id_q <= g_id;
            end
         end else if (ev_ok) begin
            pend_v_q  <= 1'b1;
            pend_id_q <= g_id;
         end
         if (ev_bad)         err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;
         if (ovr_set)        ovr_o <= 1'b1;
         else if (err_clr_i) ovr_o <= 1'b0;
      end
   end

`ifdef GRANT_DISPATCH_STATS_EN
   for (genvar k = 0; k < NUM_USERS; k++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q;
      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n)
            cnt_q <= '0;
         else if ((state_q == ISSUE) && (id_q == uid_t'(k)) && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
      end
      assign grant_cnt_o[(NUM_USERS-1-k)*CNT_W +: CNT_W] = cnt_q;
   end
`else
   assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_grant_dispatch.sv
// tb_grant_dispatch: directed vector table, hand-written corner sequences and a
// randomized run, all checked cycle by cycle against a session-level model.
module tb_grant_dispatch;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 2;

   logic               clock = 1'b0;
   logic               rst_n;
   logic [3:0]         grant_i, done_i;
   logic               err_clr_i;
   logic [3:0]         sel_o;
   logic               start_o, busy_o, timeout_o, err_o, ovr_o;
   logic [1:0]         active_id_o;
   logic [4*CNT_W-1:0] grant_cnt_o;

   int n_chk = 0;
   int n_err = 0;

   grant_dispatch #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .grant_i     (grant_i),
      .done_i      (done_i),
      .err_clr_i   (err_clr_i),
      .sel_o       (sel_o),
      .start_o     (start_o),
      .active_id_o (active_id_o),
      .busy_o      (busy_o),
      .timeout_o   (timeout_o),
      .err_o       (err_o),
      .ovr_o       (ovr_o),
      .grant_cnt_o (grant_cnt_o)
   );

   always #5 clock = ~clock;

   // ---------------- session-level reference model ----------------
   bit         m_act;       // a session is in progress
   int         m_user;      // its user (0=U1..3=U4)
   int         m_age;       // cycles since its start cycle
   int         m_pend[$];   // waiting grant, at most one
   logic [3:0] m_prev;      // grant word seen last cycle
   bit         m_err, m_ovr;
   int         m_cnt[4];

   task automatic model_reset();
      m_act = 0; m_user = 0; m_age = 0; m_pend.delete();
      m_prev = 4'b0000; m_err = 0; m_ovr = 0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [3:0]         esel;
      bit                 hit;
      logic [4*CNT_W-1:0] ecnt;
      esel = m_act ? (4'b1000 >> m_user) : 4'b0000;
      hit  = m_act && (m_age >= 1) && done_i[3-m_user];
      ecnt = '0;
`ifdef GRANT_DISPATCH_STATS_EN
      for (int k = 0; k < 4; k++) ecnt[(3-k)*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
`endif
      chk("m_start",   start_o,     32'(m_act && m_age == 0));
      chk("m_sel",     sel_o,       32'(esel));
      chk("m_busy",    busy_o,      32'(m_act));
      chk("m_id",      active_id_o, m_act ? 32'(m_user) : 32'd0);
      chk("m_timeout", timeout_o,   32'(m_act && m_age == TIMEOUT && !hit));
      chk("m_err",     err_o,       32'(m_err));
      chk("m_ovr",     ovr_o,       32'(m_ovr));
      chk("m_cnt",     grant_cnt_o, 32'(ecnt));
   endtask

   task automatic model_update();
      bit ev, ok, hit, ends, oset;
      int u;
      if (!rst_n) begin
         model_reset();
      end else begin
         ev   = (grant_i != m_prev) && (grant_i != 4'b0000);
         ok   = ev && ($countones(grant_i) == 1);
         u    = 0;
         for (int k = 0; k < 4; k++) if (grant_i == (4'b1000 >> k)) u = k;
         hit  = m_act && (m_age >= 1) && done_i[3-m_user];
         ends = m_act && (hit || m_age == TIMEOUT);
         oset = 0;
         if (ev && !ok)      m_err = 1;
         else if (err_clr_i) m_err = 0;
         if (m_act) begin
            if (ok) begin
               if (m_pend.size() > 0) begin m_pend[0] = u; oset = 1; end
               else m_pend.push_back(u);
            end
            if (m_age == 0 && m_cnt[m_user] < (1 << CNT_W) - 1) m_cnt[m_user]++;
            if (ends) m_act = 0;
            else      m_age++;
         end else if (m_pend.size() > 0) begin
            m_user = m_pend.pop_front(); m_act = 1; m_age = 0;
            if (ok) m_pend.push_back(u);
         end else if (ok) begin
            m_user = u; m_act = 1; m_age = 0;
         end
         if (oset)           m_ovr = 1;
         else if (err_clr_i) m_ovr = 0;
         m_prev = grant_i;
      end
   endtask

   task automatic half_check(); @(negedge clock); model_check(); endtask
   task automatic half_edge();  @(posedge clock); model_update(); #1; endtask
   task automatic step();       half_check(); half_edge(); endtask

   task automatic run_session(input logic [3:0] g);
      grant_i = g; step();        // event
      step();                     // start cycle
      done_i = g; step();         // done in first hold cycle
      done_i = 4'b0000; step();   // back to idle
   endtask

   task automatic do_reset();
      rst_n = 1'b0; model_reset();
      step(); step();
      rst_n = 1'b1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0] g, d;
      logic       clr;
      logic       st;
      logic [3:0] sel;
      logic       bsy, tmo, er;
      logic [1:0] id;
   } vec_t;

   vec_t vt[15];

   initial begin
      int tpos, tcnt;
      logic [3:0] first_sel;
      bit saw_u3, bz17, bz16, st0;
      logic [CNT_W-1:0] exp_f;

      //         g        d        clr  st   sel      bsy  tmo  er   id
      vt[0]  = '{4'b0000, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};
      vt[1]  = '{4'b1000, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};
      vt[2]  = '{4'b1000, 4'b0000, 0,   1,   4'b1000, 1,   0,   0,   0};
      vt[3]  = '{4'b1000, 4'b0000, 0,   0,   4'b1000, 1,   0,   0,   0};
      vt[4]  = '{4'b1000, 4'b1000, 0,   0,   4'b1000, 1,   0,   0,   0};
      vt[5]  = '{4'b1000, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};
      vt[6]  = '{4'b0110, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};
      vt[7]  = '{4'b0110, 4'b0000, 0,   0,   4'b0000, 0,   0,   1,   0};
      vt[8]  = '{4'b0110, 4'b0000, 1,   0,   4'b0000, 0,   0,   1,   0};
      vt[9]  = '{4'b0000, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};
      vt[10] = '{4'b0100, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};
      vt[11] = '{4'b0100, 4'b0000, 0,   1,   4'b0100, 1,   0,   0,   1};
      vt[12] = '{4'b0100, 4'b1000, 0,   0,   4'b0100, 1,   0,   0,   1};
      vt[13] = '{4'b0100, 4'b0100, 0,   0,   4'b0100, 1,   0,   0,   1};
      vt[14] = '{4'b0000, 4'b0000, 0,   0,   4'b0000, 0,   0,   0,   0};

      grant_i = 4'b0000; done_i = 4'b0000; err_clr_i = 1'b0;
      rst_n = 1'b0; model_reset();
      @(posedge clock); #1;
      half_check();
      chk("rst_busy", busy_o, 0);
      chk("rst_sel", sel_o, 0);
      chk("rst_cnt", grant_cnt_o, 0);
      half_edge();
      step();
      rst_n = 1'b1;

      // table: test 1 (U1 session), test 4 (bad grant + clear), ignored done
      for (int i = 0; i < 15; i++) begin
         grant_i = vt[i].g; done_i = vt[i].d; err_clr_i = vt[i].clr;
         half_check();
         chk($sformatf("v%0d_start", i), start_o, 32'(vt[i].st));
         chk($sformatf("v%0d_sel", i), sel_o, 32'(vt[i].sel));
         chk($sformatf("v%0d_busy", i), busy_o, 32'(vt[i].bsy));
         chk($sformatf("v%0d_tmo", i), timeout_o, 32'(vt[i].tmo));
         chk($sformatf("v%0d_err", i), err_o, 32'(vt[i].er));
         chk($sformatf("v%0d_id", i), active_id_o, 32'(vt[i].id));
         half_edge();
      end
      done_i = 4'b0000; err_clr_i = 1'b0;

      // test 2: timeout pulse 16 cycles after start, busy low the cycle after
      grant_i = 4'b0100; step();
      tpos = -1; tcnt = 0; bz16 = 0; bz17 = 1; st0 = 0;
      for (int i = 0; i <= 20; i++) begin
         half_check();
         if (i == 0) st0 = start_o;
         if (timeout_o) begin tcnt++; tpos = i; end
         if (i == 16) bz16 = busy_o;
         if (i == 17) bz17 = busy_o;
         half_edge();
      end
      chk("t2_start", st0, 1);
      chk("t2_tmo_count", tcnt, 1);
      chk("t2_tmo_pos", tpos, 16);
      chk("t2_busy_at_tmo", bz16, 1);
      chk("t2_busy_after", bz17, 0);

      // test 3: two grants mid-session, newest kept, ovr raised
      grant_i = 4'b0000; step();
      grant_i = 4'b1000; step(); step(); step();
      grant_i = 4'b0010; step();
      grant_i = 4'b0001; step();
      done_i = 4'b1000;
      half_check();
      chk("t3_ovr", ovr_o, 1);
      chk("t3_sel_u1", sel_o, 4'b1000);
      half_edge();
      done_i = 4'b0000;
      first_sel = 4'b0000; saw_u3 = 0;
      for (int i = 0; i < 4; i++) begin
         half_check();
         if (start_o && first_sel == 4'b0000) first_sel = sel_o;
         if (sel_o == 4'b0010) saw_u3 = 1;
         half_edge();
      end
      chk("t3_next_sel", first_sel, 4'b0001);
      chk("t3_no_u3", saw_u3, 0);
      done_i = 4'b0001; step();
      done_i = 4'b0000; grant_i = 4'b0000; step();
      err_clr_i = 1'b1; step();
      err_clr_i = 1'b0;
      half_check();
      chk("t3_ovr_clr", ovr_o, 0);
      half_edge();

      // test 5: reset mid-hold with grant held, fresh session after release
      grant_i = 4'b1000; step(); step(); step();
      rst_n = 1'b0; model_reset(); #1;
      chk("t5_busy_imm", busy_o, 0);
      chk("t5_sel_imm", sel_o, 0);
      chk("t5_tmo_imm", timeout_o, 0);
      half_edge();
      step();
      rst_n = 1'b1;
      half_check();
      chk("t5_idle_rel", busy_o, 0);
      half_edge();
      half_check();
      chk("t5_restart", start_o, 1);
      chk("t5_restart_sel", sel_o, 4'b1000);
      half_edge();
      done_i = 4'b1000; step();
      done_i = 4'b0000; grant_i = 4'b0000; step();

      // test 6: counters (U2 field), then saturation with CNT_W=2
      do_reset();
      run_session(4'b0100); run_session(4'b0010); run_session(4'b0100);
      run_session(4'b0010); run_session(4'b0100);
      exp_f = '0;
`ifdef GRANT_DISPATCH_STATS_EN
      exp_f = 2'd3;
`endif
      half_check();
      chk("t6_u2_cnt", grant_cnt_o[2*CNT_W +: CNT_W], 32'(exp_f));
      half_edge();
      run_session(4'b0010); run_session(4'b0100);
      run_session(4'b0010); run_session(4'b0100);
      half_check();
      chk("t6_u2_sat", grant_cnt_o[2*CNT_W +: CNT_W], 32'(exp_f));
      half_edge();

      // randomized run against the model
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = $urandom % 100;
         if (r < 60)      grant_i = grant_i;
         else if (r < 88) grant_i = 4'b1000 >> ($urandom % 4);
         else if (r < 96) grant_i = 4'b0000;
         else             grant_i = 4'($urandom);
         done_i    = ($urandom % 8 == 0) ? 4'($urandom) : 4'b0000;
         err_clr_i = ($urandom % 40 == 0);
         if ($urandom % 500 == 0) begin rst_n = 1'b0; model_reset(); end
         else rst_n = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
